// File: rtl/btn_timebase.sv
// Push-button front end: two-flop synchronizer plus debouncer, and a saturating
// elapsed-time counter that raises 0.5 s / 3 s / 5 s level flags.
module btn_timebase #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clock,
  input  logic rst,
  input  logic button_raw,
  input  logic cnt_rst,
  output logic button,
  output logic sec_half,
  output logic sec_3,
  output logic sec_5
);

  localparam longint T_HALF = longint'(CLK_HZ) / 2;
  localparam longint T3     = 3 * longint'(CLK_HZ);
  localparam longint T5     = 5 * longint'(CLK_HZ);
  localparam int     CNT_W  = $clog2(T5 + 1);
  localparam int     MC_W   = $clog2(longint'(DEB_CYCLES) + 1);

  localparam logic [CNT_W-1:0] T_HALF_C = CNT_W'(T_HALF);
  localparam logic [CNT_W-1:0] T3_C     = CNT_W'(T3);
  localparam logic [CNT_W-1:0] T5_C     = CNT_W'(T5);
  // The edge that sees this mismatch count is the one where mc would reach DEB_CYCLES.
  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             btn_q, btn_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    btn_d = btn_q;
    mc_d  = '0;
    if (s2_q != btn_q) begin
      if (mc_q == MC_LAST) begin
        btn_d = s2_q;
      end else begin
        mc_d = mc_q + MC_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    if (cnt_rst) begin
      cnt_d = (cnt_q == T5_C) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      btn_q <= 1'b0;
      mc_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= button_raw;
      s2_q  <= s1_q;
      btn_q <= btn_d;
      mc_q  <= mc_d;
      cnt_q <= cnt_d;
    end
  end

  // Flags decode only the registered count, so they are clean levels.
  assign button   = btn_q;
  assign sec_half = (cnt_q >= T_HALF_C);
  assign sec_3    = (cnt_q >= T3_C);
  assign sec_5    = (cnt_q >= T5_C);

endmodule
